ins_cache: RTL

INS_CACHE -- requirements
Module: ins_cache

---
 rtl/ins_cache.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ins_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines of 16 bytes, zero-cycle hits, block refill on miss.
// Define ICACHE_STATS_EN to add the saturating hit_count / miss_count outputs.
module ins_cache #(
    parameter int unsigned NLINES = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int unsigned TAG_W  = 3;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned WORD_W = 2;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned BLK_W  = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic [WORD_W-1:0] addr_word;
    logic              unused_byte_bits;

    logic [NLINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_arr  [NLINES];
    logic [LINE_W-1:0] data_arr [NLINES];

    logic [BLK_W-1:0]  miss_addr_q, miss_addr_d;
    logic              mem_read_q, mem_read_d;
    logic [BLK_W-1:0]  mem_address_q, mem_address_d;
    logic              line_wr;
    logic              hit;

    assign addr_tag         = address[9:7];
    assign addr_idx         = address[6:4];
    assign addr_word        = address[3:2];
    assign unused_byte_bits = ^address[1:0];

    assign hit = read && valid_q[addr_idx] && (tag_arr[addr_idx] == addr_tag);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (read && !hit) state_d = MEM_READ;
            MEM_READ: if (!mem_busywait) state_d = UPDATE;
            UPDATE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output and datapath-control logic
    always_comb begin
        instruction   = 32'h0;
        busywait      = 1'b0;
        miss_addr_d   = miss_addr_q;
        mem_read_d    = 1'b0;
        mem_address_d = mem_address_q;
        valid_d       = valid_q;
        line_wr       = 1'b0;

        if (hit) begin
            instruction = data_arr[addr_idx][{addr_word, 5'd0} +: 32];
        end
        busywait = read && (!hit || (state_q != IDLE));

        if ((state_q == IDLE) && (state_d == MEM_READ)) begin
            miss_addr_d   = {addr_tag, addr_idx};
            mem_address_d = {addr_tag, addr_idx};
        end
        if (state_d == MEM_READ) begin
            mem_read_d = 1'b1;
        end

        // Fill commits on the MEM_READ -> UPDATE edge
        if ((state_q == MEM_READ) && (state_d == UPDATE)) begin
            line_wr                     = 1'b1;
            valid_d[miss_addr_q[IDX_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q       <= '0;
            miss_addr_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
        end else begin
            valid_q       <= valid_d;
            miss_addr_q   <= miss_addr_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use
    always_ff @(posedge clock) begin
        if (line_wr) begin
            tag_arr[miss_addr_q[IDX_W-1:0]]  <= miss_addr_q[BLK_W-1:IDX_W];
            data_arr[miss_addr_q[IDX_W-1:0]] <= mem_readdata;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;

`ifdef ICACHE_STATS_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    // Saturating event counters
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if ((state_q == IDLE) && (state_d == MEM_READ) && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
